// File: rtl/debug_monitor_mem_ctrl.sv
// debug_monitor_mem_ctrl: decodes the debug slave's sysclk-side strobes into single-word debug RAM accesses.
// The address auto-increments after each access. Read data, ready and a sticky error flag go back to the monitor.
// Optional macro DBG_MON_TIMEOUT_EN aborts an access that stalls for TO_CYC cycles.
module debug_monitor_mem_ctrl #(
   parameter int AW     = 9,
   parameter int TO_CYC = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [37:0]   jdo,
   input  logic          take_action_ocimem_a,
   input  logic          take_action_ocimem_b,
   input  logic          take_no_action_ocimem_a,
   output logic [31:0]   MonDReg,
   output logic          monitor_ready,
   output logic          monitor_error,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read,
   output logic          mem_write,
   output logic [31:0]   mem_wdata,
   input  logic          mem_waitrequest,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_rdvalid
);
   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   mon_q, mon_d, wdata_q, wdata_d;
   logic          err_q, err_d, ready_q, ready_d, rd_q, rd_d, wr_q, wr_d;
   logic          idle, acc_a, acc_b, acc_n, drop, rd_acc, rd_done, wr_acc, timeout, abort;
   logic          unused_jdo;
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
   // only one strobe is taken per cycle (a > b > no_action), and only in IDLE; every other strobe is lost
   assign idle    = state_q == IDLE;
   assign acc_a   = idle && take_action_ocimem_a;
   assign acc_b   = idle && !take_action_ocimem_a && take_action_ocimem_b;
   assign acc_n   = idle && !take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a;
   assign drop    = idle ? (take_action_ocimem_a && (take_action_ocimem_b || take_no_action_ocimem_a)) ||
                           (take_action_ocimem_b && take_no_action_ocimem_a)
                         : take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
   assign rd_acc  = state_q == RD_REQ && !mem_waitrequest;
   assign rd_done = state_q == RD_WAIT && mem_rdvalid;
   assign wr_acc  = state_q == WR_REQ && !mem_waitrequest;
   assign abort   = timeout && !(rd_acc || rd_done || wr_acc);
`ifdef DBG_MON_TIMEOUT_EN
   logic [15:0] cnt_q;
   assign timeout = !idle && cnt_q == 16'(TO_CYC - 1);
   // wait-cycle counter, restarted whenever the FSM changes state
   always_ff @(posedge clk)
      if (!reset_n || idle || state_d != state_q) cnt_q <= '0;
      else cnt_q <= cnt_q + 16'd1;
`else
   logic unused_to;
   assign unused_to = TO_CYC != 0;
   assign timeout   = 1'b0;
`endif
   // state register
   always_ff @(posedge clk)
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;
   // next state; a completion on the same cycle as a timeout wins
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (acc_a && jdo[34]) || acc_n ? RD_REQ : acc_b ? WR_REQ : IDLE;
         RD_REQ:  state_d = !mem_waitrequest ? RD_WAIT : timeout ? IDLE : RD_REQ;
         RD_WAIT: state_d = mem_rdvalid || timeout ? IDLE : RD_WAIT;
         default: state_d = !mem_waitrequest || timeout ? IDLE : WR_REQ;
      endcase
   end
   // datapath and registered outputs; requests follow the next state so they are glitch-free flops
   always_comb begin
      addr_d  = acc_a ? jdo[AW+16:17] : (rd_acc || wr_acc) ? addr_q + AW'(1) : addr_q;
      wdata_d = acc_b ? jdo[34:3] : wdata_q;
      mon_d   = rd_done ? mem_rdata : abort ? 32'hDEAD_BEEF : mon_q;
      err_d   = (acc_a ? 1'b0 : err_q) | drop | abort;
      ready_d = state_d == IDLE;
      rd_d    = state_d == RD_REQ;
      wr_d    = state_d == WR_REQ;
   end
   // datapath register
   always_ff @(posedge clk)
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         mon_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mon_q   <= mon_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   assign MonDReg       = mon_q;
   assign monitor_ready = ready_q;
   assign monitor_error = err_q;
   assign mem_addr      = addr_q;
   assign mem_read      = rd_q;
   assign mem_write     = wr_q;
   assign mem_wdata     = wdata_q;
endmodule

// File: tb/tb_debug_monitor_mem_ctrl.sv
// tb_debug_monitor_mem_ctrl: directed and randomized commands checked against a transaction-level monitor model
module tb_debug_monitor_mem_ctrl;
   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;
   logic          clk = 0, reset_n = 0;
   logic [37:0]   jdo = '0;
   logic          sa = 0, sb = 0, sn = 0;
   logic [31:0]   MonDReg;
   logic          monitor_ready, monitor_error;
   logic [AW-1:0] mem_addr;
   logic          mem_read, mem_write;
   logic [31:0]   mem_wdata;
   logic          mem_waitrequest = 0, mem_rdvalid = 0;
   logic [31:0]   mem_rdata = 0;

   debug_monitor_mem_ctrl #(.AW(AW), .TO_CYC(4)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(sa), .take_action_ocimem_b(sb), .take_no_action_ocimem_a(sn),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_waitrequest(mem_waitrequest), .mem_rdata(mem_rdata), .mem_rdvalid(mem_rdvalid)
   );

   always #5 clk = ~clk;

   int            n_chk = 0, n_fail = 0;
   logic [31:0]   ram [DEPTH];
   logic [31:0]   ref_mem [DEPTH];
   int            wait_mode = 0, wait_force = 0, rd_lat = 1;
   int            n_rd = 0, n_wr = 0, both_hi = 0, stab_err = 0;
   int            pend = 0, consec = 0;
   logic [31:0]   pdata = 0, p_wd = 0;
   logic          p_req = 0, p_wait = 0, p_rd = 0;
   logic [AW-1:0] p_addr = 0;
   logic [AW-1:0] m_addr = 0;
   logic [31:0]   m_mon = 0;
   logic          m_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM responder: accepts requests when waitrequest is low, returns read data rd_lat cycles later
   initial forever begin
      @(posedge clk);
      if (mem_read && mem_write) both_hi++;
      if (p_req && p_wait) begin
         if (mem_read || mem_write) begin
            if (mem_read != p_rd || mem_addr != p_addr || (!p_rd && mem_wdata != p_wd)) stab_err++;
         end
`ifndef DBG_MON_TIMEOUT_EN
         else stab_err++;
`endif
      end
      p_req = mem_read || mem_write; p_wait = mem_waitrequest; p_rd = mem_read; p_addr = mem_addr; p_wd = mem_wdata;
      if (mem_write && !mem_waitrequest) begin ram[mem_addr] = mem_wdata; n_wr++; end
      if (mem_read && !mem_waitrequest) begin n_rd++; pend = rd_lat; pdata = ram[mem_addr]; end
      #1;
      mem_rdvalid = 0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin mem_rdvalid = 1; mem_rdata = pdata; end
      end
      if (wait_force > 0) begin mem_waitrequest = 1; wait_force--; end
      else if (wait_mode == 2) mem_waitrequest = 1;
      else if (wait_mode == 1 && consec < 2) mem_waitrequest = $urandom_range(0, 2) == 0;
      else mem_waitrequest = 0;
      consec = mem_waitrequest ? consec + 1 : 0;
   end

   function automatic logic [37:0] mk_a(input logic [AW-1:0] ad, input logic rd);
      logic [37:0] d = 38'({$urandom, $urandom});
      d[AW+16:17] = ad;
      d[34] = rd;
      return d;
   endfunction

   function automatic logic [37:0] mk_b(input logic [31:0] w);
      logic [37:0] d = 38'({$urandom, $urandom});
      d[34:3] = w;
      return d;
   endfunction

   // drive a one-cycle strobe from a negedge; returns at the following negedge
   task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] d);
      jdo = d; sa = a; sb = b; sn = n;
      @(negedge clk);
      sa = 0; sb = 0; sn = 0; jdo = 38'({$urandom, $urandom});
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (monitor_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk({tag, " ready"}, 64'(monitor_ready), 64'd1);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " MonDReg"}, 64'(MonDReg), 64'(m_mon));
      chk({tag, " error"}, 64'(monitor_error), 64'(m_err));
      chk({tag, " addr"}, 64'(mem_addr), 64'(m_addr));
   endtask

   // one monitor command (0 load, 1 write, 2 read), optionally followed by an overrunning strobe
   task automatic run(input int kind, input logic [AW-1:0] ad, input logic rd, input logic [31:0] w, input logic ovr);
      logic busy;
      int   s;
      busy = kind != 0 || rd;
      if (kind == 0) begin
         strobe(1, 0, 0, mk_a(ad, rd));
         m_addr = ad; m_err = 0;
         if (rd) begin m_mon = ref_mem[ad]; m_addr = ad + 1'b1; end
      end else if (kind == 1) begin
         strobe(0, 1, 0, mk_b(w));
         ref_mem[m_addr] = w; m_addr = m_addr + 1'b1;
      end else begin
         strobe(0, 0, 1, mk_a(ad, rd));
         m_mon = ref_mem[m_addr]; m_addr = m_addr + 1'b1;
      end
      chk("rnd ready after accept", 64'(monitor_ready), 64'(!busy));
      if (ovr && busy) begin
         s = $urandom_range(0, 2);
         strobe(s == 0, s == 1, s == 2, 38'({$urandom, $urandom}));
         m_err = 1;
      end
      wait_ready("rnd");
      check_model("rnd");
   endtask

   initial begin
      int wr0, r0, diffs;
      for (int i = 0; i < DEPTH; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
      repeat (3) @(negedge clk);
      chk("rst ready", 64'(monitor_ready), 64'd1);
      chk("rst error", 64'(monitor_error), 64'd0);
      chk("rst MonDReg", 64'(MonDReg), 64'd0);
      chk("rst addr", 64'(mem_addr), 64'd0);
      chk("rst read", 64'(mem_read), 64'd0);
      chk("rst write", 64'(mem_write), 64'd0);
      chk("rst wdata", 64'(mem_wdata), 64'd0);
      reset_n = 1;
      @(negedge clk);

      ram[5] = 32'h1234_5678; ref_mem[5] = 32'h1234_5678;
      strobe(1, 0, 0, mk_a(AW'(5), 1));
      chk("lr read req", 64'(mem_read), 64'd1);
      chk("lr read addr", 64'(mem_addr), 64'd5);
      chk("lr ready low", 64'(monitor_ready), 64'd0);
      @(negedge clk);
      chk("lr req dropped", 64'(mem_read), 64'd0);
      chk("lr ready still low", 64'(monitor_ready), 64'd0);
      chk("lr addr inc", 64'(mem_addr), 64'd6);
      @(negedge clk);
      chk("lr ready at 3clk", 64'(monitor_ready), 64'd1);
      chk("lr MonDReg", 64'(MonDReg), 64'h1234_5678);
      m_addr = 6; m_mon = 32'h1234_5678; m_err = 0;

      strobe(1, 0, 0, mk_a(AW'(DEPTH - 1), 0));
      chk("wr load ready", 64'(monitor_ready), 64'd1);
      chk("wr load addr", 64'(mem_addr), 64'(DEPTH - 1));
      wait_force = 2;
      strobe(0, 1, 0, mk_b(32'hA5A5_0001));
      for (int i = 0; i < 3; i++) begin
         chk("wr held write", 64'(mem_write), 64'd1);
         chk("wr held addr", 64'(mem_addr), 64'(DEPTH - 1));
         chk("wr held data", 64'(mem_wdata), 64'hA5A5_0001);
         @(negedge clk);
      end
      chk("wr released", 64'(mem_write), 64'd0);
      chk("wr wrap addr", 64'(mem_addr), 64'd0);
      chk("wr ready", 64'(monitor_ready), 64'd1);
      chk("wr ram word", 64'(ram[DEPTH-1]), 64'hA5A5_0001);
      ref_mem[DEPTH-1] = 32'hA5A5_0001; m_addr = 0;

      rd_lat = 3;
      strobe(1, 0, 0, mk_a(AW'(10), 1));
      @(negedge clk);
      wr0 = n_wr;
      strobe(0, 1, 0, mk_b(32'hFFFF_0000));
      wait_ready("ovr");
      chk("ovr error", 64'(monitor_error), 64'd1);
      chk("ovr MonDReg", 64'(MonDReg), 64'(ref_mem[10]));
      chk("ovr addr", 64'(mem_addr), 64'd11);
      chk("ovr no write", 64'(n_wr), 64'(wr0));
      strobe(1, 0, 0, mk_a(AW'(20), 0));
      chk("ovr error cleared", 64'(monitor_error), 64'd0);
      chk("ovr load addr", 64'(mem_addr), 64'd20);

      rd_lat = 1; r0 = n_rd;
      strobe(1, 0, 1, mk_a(AW'(30), 1));
      chk("coin error", 64'(monitor_error), 64'd1);
      wait_ready("coin");
      chk("coin MonDReg", 64'(MonDReg), 64'(ref_mem[30]));
      chk("coin addr", 64'(mem_addr), 64'd31);
      chk("coin one read", 64'(n_rd - r0), 64'd1);
      strobe(1, 0, 0, mk_a(AW'(31), 0));
      chk("coin error cleared", 64'(monitor_error), 64'd0);

      rd_lat = 4;
      strobe(1, 0, 0, mk_a(AW'(40), 1));
      strobe(0, 1, 0, mk_b(32'h0));
      chk("mid error set", 64'(monitor_error), 64'd1);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      chk("mid ready", 64'(monitor_ready), 64'd1);
      chk("mid error", 64'(monitor_error), 64'd0);
      chk("mid read", 64'(mem_read), 64'd0);
      chk("mid MonDReg", 64'(MonDReg), 64'd0);
      chk("mid addr", 64'(mem_addr), 64'd0);
      repeat (4) @(negedge clk);
      chk("late rdvalid MonDReg", 64'(MonDReg), 64'd0);
      chk("late rdvalid ready", 64'(monitor_ready), 64'd1);
      m_addr = 0; m_mon = 0; m_err = 0;

      rd_lat = 1; wait_mode = 2;
      strobe(0, 0, 1, '0);
      repeat (3) @(negedge clk);
      chk("stall req held", 64'(mem_read), 64'd1);
      @(negedge clk);
`ifdef DBG_MON_TIMEOUT_EN
      chk("to req dropped", 64'(mem_read), 64'd0);
      chk("to ready", 64'(monitor_ready), 64'd1);
      m_err = 1; m_mon = 32'hDEAD_BEEF;
      wait_mode = 0;
      check_model("to");
`else
      repeat (15) @(negedge clk);
      chk("stall still req", 64'(mem_read), 64'd1);
      chk("stall not ready", 64'(monitor_ready), 64'd0);
      wait_mode = 0;
      m_mon = ref_mem[m_addr]; m_addr = m_addr + 1'b1;
      wait_ready("stall release");
      check_model("stall release");
`endif

      for (int i = 0; i < 80; i++) begin
         wait_mode = 1;
         rd_lat = $urandom_range(1, 3);
         run($urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5) == 0);
      end
      wait_mode = 0;
      repeat (5) @(negedge clk);

      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) diffs++;
      chk("ram image", 64'(diffs), 64'd0);
      chk("rd/wr overlap", 64'(both_hi), 64'd0);
      chk("request stability", 64'(stab_err), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
